// File: rtl/cu_fsm.sv
// ---------------------------------------------------------------------------
// cu_fsm
// Control unit for the 8-bit accumulator processor. It runs a
// fetch / decode / execute state machine and turns the current state, the
// opcode and the accumulator flags into datapath control strobes. It also
// synchronises and edge-detects the Enter pushbutton that the IN
// instruction waits on.
//
// Ports
//   clock     in   1  system clock, rising edge
//   reset     in   1  asynchronous, active-high reset
//   enter     in   1  raw pushbutton, asynchronous to clock
//   ir        in   3  opcode from datapath IR[7:5]
//   aeq0      in   1  A == 0 flag
//   apos      in   1  A[7] == 0 flag
//   ir_load   out  1  load IR from RAM data
//   jmp_mux   out  1  PC source: 0 = PC+1, 1 = IR[4:0]
//   pc_load   out  1  load PC
//   mem_inst  out  1  RAM address: 0 = PC, 1 = IR[4:0]
//   mem_wr    out  1  RAM write strobe
//   a_load    out  1  load A
//   sub       out  1  addsub op: 0 = add, 1 = subtract
//   a_sel     out  2  A source: 00 addsub, 01 input, 10 RAM, 11 8'hFF
//   halt      out  1  high while halted
//   state     out  4  current state code, for debug
// ---------------------------------------------------------------------------
module cu_fsm #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enter,
   input  logic [2:0] ir,
   input  logic       aeq0,
   input  logic       apos,
   output logic       ir_load,
   output logic       jmp_mux,
   output logic       pc_load,
   output logic       mem_inst,
   output logic       mem_wr,
   output logic       a_load,
   output logic       sub,
   output logic [1:0] a_sel,
   output logic       halt,
   output logic [3:0] state
);

   // Execute states sit at 8 + opcode so DECODE can jump straight to them.
   typedef enum logic [3:0] {
      S_START  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_LOAD   = 4'd8,
      S_STORE  = 4'd9,
      S_ADD    = 4'd10,
      S_SUB    = 4'd11,
      S_IN     = 4'd12,
      S_JZ     = 4'd13,
      S_JPOS   = 4'd14,
      S_HALT   = 4'd15
   } state_t;

   state_t                 cur;
   logic [SYNC_STAGES-1:0] syncFf;
   logic                   hist;
   logic                   enterRise;

   // Enter synchroniser chain plus one history flop. The button is sampled
   // continuously, so a press that happens outside IN has already been
   // consumed by the time IN is reached, and a button held on entry to IN
   // produces no edge until it is released and pressed again.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         syncFf <= '0;
         hist   <= 1'b0;
      end else begin
         syncFf <= {syncFf[SYNC_STAGES-2:0], enter};
         hist   <= syncFf[SYNC_STAGES-1];
      end
   end

   // One-cycle pulse per press of the synchronised button.
   assign enterRise = syncFf[SYNC_STAGES-1] & ~hist;

   // State register and next-state logic. Unused encodings fall back to
   // START so a corrupted state recovers within one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur <= S_START;
      end else begin
         case (cur)
            S_START:  cur <= S_FETCH;
            S_FETCH:  cur <= S_DECODE;
            S_DECODE: cur <= state_t'({1'b1, ir});
            S_LOAD,
            S_STORE,
            S_ADD,
            S_SUB,
            S_JZ,
            S_JPOS:   cur <= S_FETCH;
            S_IN: begin
               if (enterRise) begin
                  cur <= S_FETCH;
               end
            end
            S_HALT:   cur <= S_HALT;
            default:  cur <= S_START;
         endcase
      end
   end

   // Control decode. Outputs follow the state register combinationally so
   // that an asynchronous reset drops every strobe (in particular mem_wr)
   // immediately, abandoning the current instruction without a partial
   // write. IN, JZ and JPOS additionally look at the Enter edge and flags.
   always_comb begin
      ir_load  = 1'b0;
      jmp_mux  = 1'b0;
      pc_load  = 1'b0;
      mem_inst = 1'b0;
      mem_wr   = 1'b0;
      a_load   = 1'b0;
      sub      = 1'b0;
      a_sel    = 2'b00;
      halt     = 1'b0;
      case (cur)
         S_FETCH: begin
            ir_load = 1'b1;
            pc_load = 1'b1;
         end
         S_DECODE: begin
            mem_inst = 1'b1;
         end
         S_LOAD: begin
            mem_inst = 1'b1;
            a_sel    = 2'b10;
            a_load   = 1'b1;
         end
         S_STORE: begin
            mem_inst = 1'b1;
            mem_wr   = 1'b1;
         end
         S_ADD: begin
            mem_inst = 1'b1;
            a_load   = 1'b1;
         end
         S_SUB: begin
            mem_inst = 1'b1;
            sub      = 1'b1;
            a_load   = 1'b1;
         end
         S_IN: begin
            if (enterRise) begin
               mem_inst = 1'b1;
               a_sel    = 2'b01;
               a_load   = 1'b1;
            end
         end
         S_JZ: begin
            mem_inst = 1'b1;
            jmp_mux  = aeq0;
            pc_load  = aeq0;
         end
         S_JPOS: begin
            mem_inst = 1'b1;
            jmp_mux  = apos;
            pc_load  = apos;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign state = cur;

endmodule

// File: tb/tb_cu_fsm.sv
// ---------------------------------------------------------------------------
// tb_cu_fsm
// Self-checking bench for cu_fsm. A behavioural model tracks the
// instruction phase (start / fetch / decode / execute of a latched opcode)
// and a plain delay line of sampled Enter values, and from those predicts
// every output each cycle. Directed sequences cover reset, each opcode
// class, the IN wait and HALT; a randomized run follows.
// ---------------------------------------------------------------------------
module tb_cu_fsm;

   localparam int SYNC = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       enter;
   logic [2:0] ir;
   logic       aeq0;
   logic       apos;
   logic       ir_load;
   logic       jmp_mux;
   logic       pc_load;
   logic       mem_inst;
   logic       mem_wr;
   logic       a_load;
   logic       sub;
   logic [1:0] a_sel;
   logic       halt;
   logic [3:0] state;

   int errors = 0;
   int checks = 0;

   typedef enum {M_START, M_FETCH, M_DECODE, M_EXEC} phase_t;
   phase_t    mPhase;
   int        mOp;
   bit [SYNC:0] mHist;

   cu_fsm #(.SYNC_STAGES(SYNC)) dut (
      .clock    (clock),
      .reset    (reset),
      .enter    (enter),
      .ir       (ir),
      .aeq0     (aeq0),
      .apos     (apos),
      .ir_load  (ir_load),
      .jmp_mux  (jmp_mux),
      .pc_load  (pc_load),
      .mem_inst (mem_inst),
      .mem_wr   (mem_wr),
      .a_load   (a_load),
      .sub      (sub),
      .a_sel    (a_sel),
      .halt     (halt),
      .state    (state)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Press edge as seen by the model: the delayed button went high this
   // cycle, having been low the cycle before.
   function automatic bit modelRise();
      return mHist[SYNC-1] & ~mHist[SYNC];
   endfunction

   // Expected output vector
   // {ir_load, jmp_mux, pc_load, mem_inst, mem_wr, a_load, sub, a_sel, halt, state}.
   function automatic logic [13:0] expectedOut();
      logic       il, jm, pl, mi, mw, al, sb, hl;
      logic [1:0] as;
      logic [3:0] st;
      {il, jm, pl, mi, mw, al, sb, hl} = '0;
      as = 2'b00;
      st = 4'd0;
      case (mPhase)
         M_START:  st = 4'd0;
         M_FETCH: begin
            st = 4'd1;
            il = 1'b1;
            pl = 1'b1;
         end
         M_DECODE: begin
            st = 4'd2;
            mi = 1'b1;
         end
         M_EXEC: begin
            st = 4'(8 + mOp);
            mi = 1'b1;
            case (mOp)
               0: begin as = 2'b10; al = 1'b1; end
               1: mw = 1'b1;
               2: al = 1'b1;
               3: begin sb = 1'b1; al = 1'b1; end
               4: begin
                  if (modelRise()) begin
                     as = 2'b01;
                     al = 1'b1;
                  end else begin
                     mi = 1'b0;
                  end
               end
               5: begin jm = aeq0; pl = aeq0; end
               6: begin jm = apos; pl = apos; end
               default: begin mi = 1'b0; hl = 1'b1; end
            endcase
         end
         default: st = 4'd0;
      endcase
      return {il, jm, pl, mi, mw, al, sb, as, hl, st};
   endfunction

   // Advances the model across the coming rising edge.
   task automatic modelStep();
      bit rise;
      rise = modelRise();
      case (mPhase)
         M_START:  mPhase = M_FETCH;
         M_FETCH:  mPhase = M_DECODE;
         M_DECODE: begin
            mPhase = M_EXEC;
            mOp    = int'(ir);
         end
         default: begin
            if (mOp == 7) mPhase = M_EXEC;
            else if (mOp == 4 && !rise) mPhase = M_EXEC;
            else mPhase = M_FETCH;
         end
      endcase
      mHist = {mHist[SYNC-1:0], enter};
   endtask

   // One cycle: drive inputs after the falling edge, compare the whole
   // output vector against the model, then advance the model.
   task automatic applyStimulus(input string tag, input logic r, input logic e,
                                input logic [2:0] i, input logic z, input logic p);
      @(negedge clock);
      reset = r;
      enter = e;
      ir    = i;
      aeq0  = z;
      apos  = p;
      #1;
      if (r) begin
         mPhase = M_START;
         mHist  = '0;
      end
      checkOutput(tag, 32'({ir_load, jmp_mux, pc_load, mem_inst, mem_wr, a_load,
                            sub, a_sel, halt, state}), 32'(expectedOut()));
      if (!r) modelStep();
   endtask

   // Fetch, decode and execute one non-waiting instruction; starts in FETCH.
   task automatic runInstr(input string tag, input logic [2:0] op, input logic z, input logic p);
      applyStimulus({tag, "_fetch"},  1'b0, 1'b0, op, z, p);
      applyStimulus({tag, "_decode"}, 1'b0, 1'b0, op, z, p);
      applyStimulus({tag, "_exec"},   1'b0, 1'b0, op, z, p);
   endtask

   initial begin
      int first;
      int pulses;
      int haltCnt;
      logic e;

      reset  = 1'b1;
      enter  = 1'b0;
      ir     = 3'd0;
      aeq0   = 1'b0;
      apos   = 1'b0;
      mPhase = M_START;
      mOp    = 0;
      mHist  = '0;

      // Reset value and first fetch one cycle after release.
      applyStimulus("reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      checkOutput("reset_state", 32'(state), 32'd0);
      applyStimulus("start", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      checkOutput("start_state", 32'(state), 32'd0);
      applyStimulus("fetch1", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      checkOutput("fetch1_state", 32'(state), 32'd1);

      // Reset arriving in STORE drops the write strobe immediately.
      applyStimulus("store_decode", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      applyStimulus("store_exec", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      checkOutput("store_memwr", 32'(mem_wr), 32'd1);
      applyStimulus("store_reset", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
      checkOutput("store_reset_state", 32'(state), 32'd0);
      checkOutput("store_reset_memwr", 32'(mem_wr), 32'd0);
      applyStimulus("release", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

      // Arithmetic, memory and jump opcodes.
      runInstr("load", 3'd0, 1'b0, 1'b0);
      checkOutput("load_asel", 32'(a_sel), 32'd2);
      runInstr("sub", 3'd3, 1'b0, 1'b0);
      checkOutput("sub_sub", 32'(sub), 32'd1);
      runInstr("add", 3'd2, 1'b1, 1'b1);
      runInstr("jz_taken", 3'd5, 1'b1, 1'b0);
      checkOutput("jz_taken_jmp", 32'(jmp_mux), 32'd1);
      runInstr("jz_not", 3'd5, 1'b0, 1'b1);
      checkOutput("jz_not_pcload", 32'(pc_load), 32'd0);
      runInstr("jpos_taken", 3'd6, 1'b0, 1'b1);
      runInstr("jpos_not", 3'd6, 1'b1, 1'b0);
      runInstr("store", 3'd1, 1'b0, 1'b0);

      // IN: wait with Enter low, then one load pulse per press.
      applyStimulus("in_fetch", 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
      applyStimulus("in_decode", 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         applyStimulus("in_wait", 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
      end
      checkOutput("in_wait_state", 32'(state), 32'd12);
      first  = -1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus("in_press", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
         if (a_load) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      checkOutput("in_pulse_count", 32'(pulses), 32'd1);
      checkOutput("in_latency", 32'(first), 32'(SYNC));

      // HALT holds with all strobes low, whatever Enter does.
      applyStimulus("halt_sync", 1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
      applyStimulus("halt_start", 1'b0, 1'b0, 3'd7, 1'b0, 1'b0);
      runInstr("halt", 3'd7, 1'b0, 1'b0);
      for (int k = 0; k < 100; k++) begin
         applyStimulus("halt_hold", 1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      checkOutput("halt_flag", 32'(halt), 32'd1);
      applyStimulus("halt_reset", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      checkOutput("halt_cleared", 32'(halt), 32'd0);

      // Randomized run with occasional asynchronous resets; a halted
      // machine is reset after a few cycles so execution keeps going.
      e       = 1'b0;
      haltCnt = 0;
      for (int n = 0; n < 2000; n++) begin
         logic r;
         if (mPhase == M_EXEC && mOp == 7) haltCnt++;
         else haltCnt = 0;
         r = ($urandom_range(0, 99) < 2) || (haltCnt > 5);
         if ($urandom_range(0, 5) == 0) e = ~e;
         applyStimulus("random", r, e, 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
